// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: funct3 size codes, FSM states, WB control layout.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // WB control bit positions inside the 2-bit control word
    localparam int WB_REG_WRITE_BIT  = 1;
    localparam int WB_MEM_TO_REG_BIT = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // Only the five RV32I load/store size codes touch memory
    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Pick the addressed byte/half out of the RAM word and extend it
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        b_sh = word >> {off, 3'b000};
        h_sh = word >> {off[1], 4'b0000};
        case (f3)
            F3_B:    return {{24{b_sh[7]}}, b_sh[7:0]};
            F3_BU:   return {24'h0, b_sh[7:0]};
            F3_H:    return {{16{h_sh[15]}}, h_sh[15:0]};
            F3_HU:   return {16'h0, h_sh[15:0]};
            F3_W:    return word;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM-to-MEM/WB signal bundle for the MEM stage; MEM_MISALIGN_TRAP_EN adds misalign_MEM.
// Latency: none (wires only).
// Backpressure: stall_MEM travels back from the stage (slave) to the pipeline (master).
interface mem_access_stage_if;
    import riscv_mem_pkg::*;

    logic [31:0] alu_out_EX_MEM;
    logic [31:0] rs2_EX_MEM;
    logic [4:0]  rd_EX_MEM;
    logic        mem_read_EX_MEM;
    logic        mem_write_EX_MEM;
    logic [2:0]  funct3_EX_MEM;
    wb_ctrl_t    control_MEM;
    logic [31:0] data_out;
    wb_ctrl_t    control_MEM_out;
    logic [4:0]  rd_MEM_out;
    logic        stall_MEM;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_MEM;
`endif

    modport master (
        output alu_out_EX_MEM, rs2_EX_MEM, rd_EX_MEM, mem_read_EX_MEM,
               mem_write_EX_MEM, funct3_EX_MEM, control_MEM,
`ifdef MEM_MISALIGN_TRAP_EN
        input  misalign_MEM,
`endif
        input  data_out, control_MEM_out, rd_MEM_out, stall_MEM
    );

    modport slave (
        input  alu_out_EX_MEM, rs2_EX_MEM, rd_EX_MEM, mem_read_EX_MEM,
               mem_write_EX_MEM, funct3_EX_MEM, control_MEM,
`ifdef MEM_MISALIGN_TRAP_EN
        output misalign_MEM,
`endif
        output data_out, control_MEM_out, rd_MEM_out, stall_MEM
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port byte-enabled data RAM, 2**ADDR_W 32-bit words, contents survive reset.
// Latency: 1 cycle (read data registered on the enabled edge; read-during-write returns old data).
// Backpressure: none; the caller owns access timing.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Byte-lane writes and registered read on each enabled edge
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: byte/half/word loads and stores to dmem_ram; MEM_MISALIGN_TRAP_EN traps misalignment.
// Latency: MEM_LAT+2 cycles per access (IDLE, MEM_LAT BUSY cycles, RESP); non-memory ops pass through combinationally.
// Backpressure: stall_MEM is high for MEM_LAT+1 cycles per access; control_MEM_out is a bubble while stalled.
module mem_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_stage_if.slave  bus
);

    // The IDLE cycle already counts as one stall cycle, so BUSY lasts MEM_LAT
    // cycles (at least one, since the RAM fires from BUSY).
    localparam logic [3:0] CNT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 1) : 4'd0;

    mem_state_e  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        fire;
    logic        stall;
    logic        misalign_pulse;
    wb_ctrl_t    ctrl_out;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic [31:0] addr;
    logic [2:0]  f3;
    logic        req;
    logic        is_store;
    logic        is_load;
    logic        f3_ok;
    logic        misaligned;
    logic        unused_addr_hi;

    assign addr     = bus.alu_out_EX_MEM;
    assign f3       = bus.funct3_EX_MEM;
    assign req      = bus.mem_read_EX_MEM | bus.mem_write_EX_MEM;
    assign is_store = bus.mem_write_EX_MEM;
    assign is_load  = bus.mem_read_EX_MEM & ~bus.mem_write_EX_MEM;
    assign f3_ok    = f3_valid(f3);
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = req & f3_ok &
                        (((f3[1:0] == 2'b01) & addr[0]) |
                         ((f3 == F3_W) & (addr[1:0] != 2'b00)));
    assign bus.misalign_MEM = misalign_pulse;
`else
    assign misaligned = 1'b0;
`endif

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, stall and WB control steering
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        stall          = 1'b0;
        fire           = 1'b0;
        misalign_pulse = 1'b0;
        ctrl_out       = bus.control_MEM;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    ctrl_out = '0;
                    if (misaligned) begin
                        misalign_pulse = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                stall    = 1'b1;
                ctrl_out = '0;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    fire      = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte enables and lane-replicated store data from size and low address bits
    always_comb begin
        be    = 4'b1111;
        wdata = bus.rs2_EX_MEM;
        case (f3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{bus.rs2_EX_MEM[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.rs2_EX_MEM[15:0]}};
            end
            default: ;
        endcase
    end

    // Reset on the commit edge must drop the store along with the FSM
    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (fire),
        .we    (fire & is_store & f3_ok & ~reset),
        .be    (be),
        .addr  (addr[ADDR_W+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign bus.data_out        = ((state == ST_RESP) && is_load && f3_ok) ?
                                 load_extract(rdata, f3, addr[1:0]) : 32'h0;
    assign bus.control_MEM_out = ctrl_out;
    assign bus.stall_MEM       = stall;
    assign bus.rd_MEM_out      = bus.rd_EX_MEM;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (MEM_LAT=1 and MEM_LAT=3 instances); MEM_LAT_TRAP via MEM_MISALIGN_TRAP_EN.
// Latency: expected load data queued at issue, compared when the access reaches RESP.
// Backpressure: counts stall_MEM cycles per access against MEM_LAT+1.
module tb_mem_access_stage;
    import riscv_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        reset3;
    logic        sel;
    logic        op_rd;
    logic        op_wr;
    logic [2:0]  op_f3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [1:0]  op_ctrl;
    logic [4:0]  op_rdst;

    mem_access_stage_if b1();
    mem_access_stage_if b3();

    assign b1.alu_out_EX_MEM   = op_addr;
    assign b1.rs2_EX_MEM       = op_wdata;
    assign b1.rd_EX_MEM        = op_rdst;
    assign b1.mem_read_EX_MEM  = op_rd & ~sel;
    assign b1.mem_write_EX_MEM = op_wr & ~sel;
    assign b1.funct3_EX_MEM    = op_f3;
    assign b1.control_MEM      = op_ctrl;

    assign b3.alu_out_EX_MEM   = op_addr;
    assign b3.rs2_EX_MEM       = op_wdata;
    assign b3.rd_EX_MEM        = op_rdst;
    assign b3.mem_read_EX_MEM  = op_rd & sel;
    assign b3.mem_write_EX_MEM = op_wr & sel;
    assign b3.funct3_EX_MEM    = op_f3;
    assign b3.control_MEM      = op_ctrl;

    mem_access_stage #(.ADDR_W(10), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset),  .bus(b1));
    mem_access_stage #(.ADDR_W(10), .MEM_LAT(3)) dut3 (.clk(clk), .reset(reset3), .bus(b3));

    logic        stall_o;
    logic [31:0] data_o;
    logic [1:0]  ctrl_o;
    assign stall_o = sel ? b3.stall_MEM       : b1.stall_MEM;
    assign data_o  = sel ? b3.data_out        : b1.data_out;
    assign ctrl_o  = sel ? b3.control_MEM_out : b1.control_MEM_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [1:0] c);
        op_rd = rd; op_wr = wr; op_f3 = f3; op_addr = a; op_wdata = wd; op_ctrl = c;
        op_rdst = a[6:2];
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 2'b00);
    endtask

    // Issue one access, follow it to RESP, check stall length, bubbles, controls and load data
    task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [1:0] c,
                          input logic [31:0] expd);
        int n;
        int lat;
        logic [31:0] e;
        n   = 0;
        lat = sel ? 3 : 1;
        @(negedge clk);
        drive(rd, wr, f3, a, wd, c);
        if (rd && !wr) exp_q.push_back(expd);
        #1;
        while (stall_o === 1'b1 && n < 20) begin
            total++;
            if (ctrl_o !== 2'b00) begin
                bad++;
                $display("FAIL %s bubble: control_MEM_out=%b want 00", nm, ctrl_o);
            end
            n++;
            @(negedge clk);
            #1;
        end
        total++;
        if (n != lat + 1) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, n, lat + 1);
        end
        total++;
        if (ctrl_o !== c) begin
            bad++;
            $display("FAIL %s resp_ctrl: got %b want %b", nm, ctrl_o, c);
        end
        if (rd && !wr) begin
            e = exp_q.pop_front();
            total++;
            if (data_o !== e) begin
                bad++;
                $display("FAIL %s data_out: got %h want %h", nm, data_o, e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset3 = 1'b1; sel = 1'b0;
        nop();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (b1.stall_MEM !== 1'b0 || b3.stall_MEM !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: got %b/%b want 0/0", b1.stall_MEM, b3.stall_MEM);
        end
        total++;
        if (b1.data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 00000000", b1.data_out);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        total++;
        if (b1.misalign_MEM !== 1'b0) begin
            bad++;
            $display("FAIL reset_misalign: got %b want 0", b1.misalign_MEM);
        end
`endif
        @(negedge clk);
        reset = 1'b0; reset3 = 1'b0;
    endtask

    task automatic test_word();
        access("sw_dead", 1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 2'b00, 32'h0);
        access("lw_dead", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 2'b11, 32'hDEADBEEF);
    endtask

    task automatic test_byte();
        access("sw_20",  1'b0, 1'b1, F3_W,  32'h20, 32'h11223344, 2'b00, 32'h0);
        access("sb_21",  1'b0, 1'b1, F3_B,  32'h21, 32'h12345680, 2'b00, 32'h0);
        access("lb_21",  1'b1, 1'b0, F3_B,  32'h21, 32'h0, 2'b11, 32'hFFFFFF80);
        access("lbu_21", 1'b1, 1'b0, F3_BU, 32'h21, 32'h0, 2'b11, 32'h00000080);
        access("lbu_20", 1'b1, 1'b0, F3_BU, 32'h20, 32'h0, 2'b11, 32'h00000044);
        access("lbu_22", 1'b1, 1'b0, F3_BU, 32'h22, 32'h0, 2'b11, 32'h00000022);
        access("lb_23",  1'b1, 1'b0, F3_B,  32'h23, 32'h0, 2'b11, 32'h00000011);
        access("lw_20",  1'b1, 1'b0, F3_W,  32'h20, 32'h0, 2'b11, 32'h11228044);
    endtask

    task automatic test_half();
        access("sw_30",  1'b0, 1'b1, F3_W,  32'h30, 32'h00000000, 2'b00, 32'h0);
        access("sh_32",  1'b0, 1'b1, F3_H,  32'h32, 32'hABCD8001, 2'b00, 32'h0);
        access("lh_32",  1'b1, 1'b0, F3_H,  32'h32, 32'h0, 2'b11, 32'hFFFF8001);
        access("lhu_32", 1'b1, 1'b0, F3_HU, 32'h32, 32'h0, 2'b11, 32'h00008001);
        access("lh_30",  1'b1, 1'b0, F3_H,  32'h30, 32'h0, 2'b11, 32'h00000000);
        access("lw_30",  1'b1, 1'b0, F3_W,  32'h30, 32'h0, 2'b11, 32'h80010000);
    endtask

    task automatic test_nonmem();
        logic [1:0] cv [2];
        cv[0] = 2'b10;
        cv[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, F3_W, 32'h10 + 32'(i), 32'h0, cv[i]);
            #1;
            total++;
            if (stall_o !== 1'b0 || ctrl_o !== cv[i] || data_o !== 32'h0) begin
                bad++;
                $display("FAIL nonmem_%0d: stall=%b ctrl=%b data=%h want 0 %b 00000000",
                         i, stall_o, ctrl_o, data_o, cv[i]);
            end
        end
    endtask

    task automatic test_invalid_f3();
        access("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h10, 32'h00000000, 2'b00, 32'h0);
        access("lw_after",  1'b1, 1'b0, F3_W,   32'h10, 32'h0, 2'b11, 32'hDEADBEEF);
        access("ld_f3_110", 1'b1, 1'b0, 3'b110, 32'h10, 32'h0, 2'b11, 32'h00000000);
    endtask

    task automatic test_wrap_and_both();
        access("sw_wrap",  1'b0, 1'b1, F3_W, 32'h00001044, 32'hCAFEF00D, 2'b00, 32'h0);
        access("lw_wrap",  1'b1, 1'b0, F3_W, 32'h00000044, 32'h0, 2'b11, 32'hCAFEF00D);
        access("rw_store", 1'b1, 1'b1, F3_W, 32'h50, 32'h5A5A5A5A, 2'b10, 32'h0);
        access("lw_rw",    1'b1, 1'b0, F3_W, 32'h50, 32'h0, 2'b11, 32'h5A5A5A5A);
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        drive(1'b1, 1'b0, F3_W, 32'h13, 32'h0, 2'b11);
        #1;
        total++;
        if (b1.misalign_MEM !== 1'b1 || stall_o !== 1'b0 || ctrl_o !== 2'b00) begin
            bad++;
            $display("FAIL misalign_pulse: mis=%b stall=%b ctrl=%b want 1 0 00",
                     b1.misalign_MEM, stall_o, ctrl_o);
        end
        @(negedge clk);
        nop();
        #1;
        total++;
        if (b1.misalign_MEM !== 1'b0) begin
            bad++;
            $display("FAIL misalign_clear: got %b want 0", b1.misalign_MEM);
        end
`else
        access("lw_13", 1'b1, 1'b0, F3_W, 32'h13, 32'h0, 2'b11, 32'hDEADBEEF);
        access("lh_33", 1'b1, 1'b0, F3_H, 32'h33, 32'h0, 2'b11, 32'hFFFF8001);
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        nop();
        sel = 1'b1;
        access("d3_sw_old", 1'b0, 1'b1, F3_W, 32'h40, 32'h11111111, 2'b10, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, F3_W, 32'h40, 32'h22222222, 2'b00);
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++;
            $display("FAIL d3_issue_stall: got %b want 1", stall_o);
        end
        repeat (2) @(negedge clk);
        reset3 = 1'b1;
        nop();
        @(negedge clk);
        #1;
        total++;
        if (stall_o !== 1'b0 || data_o !== 32'h0) begin
            bad++;
            $display("FAIL d3_after_reset: stall=%b data=%h want 0 00000000", stall_o, data_o);
        end
        reset3 = 1'b0;
        access("d3_lw_old", 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 2'b11, 32'h11111111);
        @(negedge clk);
        nop();
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_nonmem();
        test_invalid_f3();
        test_wrap_and_both();
        test_misalign();
        test_reset_mid();
        @(negedge clk);
        nop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
